// File: rtl/uart_tx_ctrl.sv
// ============================================================================
//  Module   : uart_tx_ctrl
//  Brief    : UART transmit sequencer; serialises start, data (LSB first),
//             optional parity and stop bits, paced by the baud tick.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx_ctrl #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud,
    output logic                 baud_sync,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam logic [3:0] c_LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] c_LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic       c_ODD       = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   tx_q, tx_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   sync_q, sync_d;
    logic                   w_tick;

    // A tick landing in the same cycle as baud_sync belongs to the old count.
    assign w_tick = baud && !sync_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sync_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_d    = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                if (tx_valid && ready_q) begin
                    shift_d = tx_data;
                    par_d   = (^tx_data) ^ c_ODD;
                    cnt_d   = 4'd0;
                    tx_d    = 1'b0;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    sync_d  = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (w_tick) begin
                    tx_d    = shift_q[0];
                    cnt_d   = 4'd0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    shift_d = shift_q >> 1;
                    if (cnt_q == c_LAST_DATA) begin
                        cnt_d = 4'd0;
                        if (PARITY_EN != 0) begin
                            tx_d    = par_q;
                            state_d = S_PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = S_STOP;
                        end
                    end else begin
                        tx_d  = shift_q[1];
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (w_tick) begin
                    tx_d    = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (w_tick) begin
                    if (cnt_q == c_LAST_STOP) begin
                        cnt_d   = 4'd0;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sync_q  <= sync_d;
        end
    end

    assign tx        = tx_q;
    assign tx_ready  = ready_q;
    assign tx_busy   = busy_q;
    assign tx_done   = done_q;
    assign baud_sync = sync_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
// ============================================================================
//  Module   : tb_uart_tx_ctrl
//  Brief    : Directed bench for uart_tx_ctrl across four parameter sets.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] baud;
    logic [3:0] valid;
    logic [7:0] tx_data;
    logic       coincide;

    logic [3:0] w_sync, w_ready, w_tx, w_busy, w_done;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int done_cnt [4] = '{0, 0, 0, 0};
    int sync_cnt [4] = '{0, 0, 0, 0};
    logic [3:0] bcnt [4];

    always #5 clk = ~clk;

    uart_tx_ctrl u0 (
        .clk(clk), .reset(reset), .baud(baud[0]), .baud_sync(w_sync[0]),
        .tx_data(tx_data), .tx_valid(valid[0]), .tx_ready(w_ready[0]),
        .tx(w_tx[0]), .tx_busy(w_busy[0]), .tx_done(w_done[0])
    );

    uart_tx_ctrl #(.PARITY_EN(1), .PARITY_ODD(0)) u1 (
        .clk(clk), .reset(reset), .baud(baud[1]), .baud_sync(w_sync[1]),
        .tx_data(tx_data), .tx_valid(valid[1]), .tx_ready(w_ready[1]),
        .tx(w_tx[1]), .tx_busy(w_busy[1]), .tx_done(w_done[1])
    );

    uart_tx_ctrl #(.PARITY_EN(1), .PARITY_ODD(1)) u2 (
        .clk(clk), .reset(reset), .baud(baud[2]), .baud_sync(w_sync[2]),
        .tx_data(tx_data), .tx_valid(valid[2]), .tx_ready(w_ready[2]),
        .tx(w_tx[2]), .tx_busy(w_busy[2]), .tx_done(w_done[2])
    );

    uart_tx_ctrl #(.STOP_BITS(2)) u3 (
        .clk(clk), .reset(reset), .baud(baud[3]), .baud_sync(w_sync[3]),
        .tx_data(tx_data), .tx_valid(valid[3]), .tx_ready(w_ready[3]),
        .tx(w_tx[3]), .tx_busy(w_busy[3]), .tx_done(w_done[3])
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Baud generator model: divide-by-16, restarted by baud_sync.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (reset || w_sync[i]) bcnt[i] = 4'd0;
            else                    bcnt[i] = bcnt[i] + 4'd1;
            baud[i] = (bcnt[i] == 4'd15) || (coincide && w_sync[i]);
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_done[i]) done_cnt[i] <= done_cnt[i] + 1;
            if (w_sync[i]) sync_cnt[i] <= sync_cnt[i] + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_sync(input int u, input string tag, output int s);
        int n = 0;
        while (w_sync[u] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_sync_latency"}, n, 1);
        s = cyc;
    endtask

    task automatic check_bits(input int u, input int s, input logic [11:0] bits,
                              input int nb, input string tag);
        for (int k = 0; k < nb; k++) begin
            wait_cyc(s + 16 * k + 8);
            chk($sformatf("%s_bit%0d", tag, k), w_tx[u], bits[k]);
        end
    endtask

    task automatic wait_done(input int u, input int s, input int nb,
                             input string tag, output int d);
        int n = 0;
        while (w_done[u] !== 1'b1 && n < 16 * nb + 40) begin
            @(negedge clk);
            n++;
        end
        d = cyc;
        chk({tag, "_done_offset"}, d - s, 16 * nb);
        chk({tag, "_ready_at_done"}, w_ready[u], 1);
        chk({tag, "_busy_at_done"}, w_busy[u], 0);
        chk({tag, "_tx_at_done"}, w_tx[u], 1);
    endtask

    initial begin
        int s, s2, d, d2, dc;
        logic idle_ok;

        reset    = 1'b1;
        valid    = 4'h0;
        tx_data  = 8'h00;
        coincide = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx",    w_tx,    4'hF);
        chk("rst_ready", w_ready, 4'hF);
        chk("rst_busy",  w_busy,  4'h0);
        chk("rst_done",  w_done,  4'h0);
        chk("rst_sync",  w_sync,  4'h0);
        reset = 1'b0;

        // Idle with ticks running and no traffic.
        idle_ok = 1'b1;
        repeat (1000) begin
            @(negedge clk);
            if (w_tx !== 4'hF || w_ready !== 4'hF || w_busy !== 4'h0 ||
                w_done !== 4'h0 || w_sync !== 4'h0)
                idle_ok = 1'b0;
        end
        chk("idle_quiet", idle_ok, 1);
        chk("idle_done_count", done_cnt[0], 0);

        // 8N1 frame of 0x55.
        tx_data  = 8'h55;
        valid[0] = 1'b1;
        wait_sync(0, "t1", s);
        valid[0] = 1'b0;
        chk("t1_tx_start",  w_tx[0],    0);
        chk("t1_ready_low", w_ready[0], 0);
        chk("t1_busy_high", w_busy[0],  1);
        check_bits(0, s, 12'h2AA, 10, "t1");
        wait_done(0, s, 10, "t1", d);
        @(negedge clk);
        chk("t1_done_width", w_done[0], 0);
        chk("t1_sync_count", sync_cnt[0], 1);

        // Even parity on 0x07: parity bit 1.
        tx_data  = 8'h07;
        valid[1] = 1'b1;
        wait_sync(1, "t2e", s);
        valid[1] = 1'b0;
        check_bits(1, s, 12'h60E, 11, "t2e");
        wait_done(1, s, 11, "t2e", d);

        // Odd parity on 0x07: parity bit 0.
        @(negedge clk);
        valid[2] = 1'b1;
        wait_sync(2, "t2o", s);
        valid[2] = 1'b0;
        check_bits(2, s, 12'h40E, 11, "t2o");
        wait_done(2, s, 11, "t2o", d);

        // Two stop bits, valid held across back-to-back frames.
        @(negedge clk);
        tx_data  = 8'hA3;
        valid[3] = 1'b1;
        wait_sync(3, "t3a", s);
        tx_data  = 8'h3C;
        check_bits(3, s, 12'h746, 11, "t3a");
        wait_done(3, s, 11, "t3a", d);
        wait_sync(3, "t3b", s2);
        valid[3] = 1'b0;
        chk("t3_accept_gap", s2 - d, 1);
        chk("t3b_tx_start", w_tx[3], 0);
        check_bits(3, s2, 12'h678, 11, "t3b");
        wait_done(3, s2, 11, "t3b", d2);
        chk("t3_done_count", done_cnt[3], 1);

        // Tick coincident with sync, then reset in data bit 4 of 0xFF.
        @(negedge clk);
        tx_data  = 8'hFF;
        coincide = 1'b1;
        valid[0] = 1'b1;
        wait_sync(0, "t4", s);
        valid[0] = 1'b0;
        wait_cyc(s + 8);
        coincide = 1'b0;
        chk("t4_start_mid", w_tx[0], 0);
        wait_cyc(s + 15);
        chk("t4_start_end", w_tx[0], 0);
        wait_cyc(s + 24);
        chk("t4_bit0", w_tx[0], 1);
        wait_cyc(s + 85);
        chk("t4_busy_bit4", w_busy[0], 1);
        dc = done_cnt[0];
        reset = 1'b1;
        @(negedge clk);
        chk("t4_rst_tx",    w_tx[0],    1);
        chk("t4_rst_busy",  w_busy[0],  0);
        chk("t4_rst_ready", w_ready[0], 1);
        chk("t4_rst_done",  w_done[0],  0);
        reset = 1'b0;
        repeat (200) @(negedge clk);
        chk("t4_no_done", done_cnt[0], dc);
        chk("t4_idle_tx", w_tx[0], 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
